// File: rtl/tcs3200_pkg.sv
// Shared codes and FSM state type for the TCS3200 colour detector.
package tcs3200_pkg;

  localparam logic [1:0] FLT_RED   = 2'd0;
  localparam logic [1:0] FLT_BLUE  = 2'd1;
  localparam logic [1:0] FLT_CLEAR = 2'd2;
  localparam logic [1:0] FLT_GREEN = 2'd3;

  localparam logic [1:0] COL_NONE  = 2'd0;
  localparam logic [1:0] COL_RED   = 2'd1;
  localparam logic [1:0] COL_GREEN = 2'd2;
  localparam logic [1:0] COL_BLUE  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GREEN = 3'd1,
    ST_RED   = 3'd2,
    ST_BLUE  = 3'd3,
    ST_CLEAR = 3'd4
  } state_e;

  // S2/S3 select driven while in a given state
  function automatic logic [1:0] filter_of(input state_e s);
    case (s)
      ST_GREEN: return FLT_GREEN;
      ST_RED:   return FLT_RED;
      ST_BLUE:  return FLT_BLUE;
      default:  return FLT_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/tcs3200_edge_sync.sv
// Two-flop synchroniser for the sensor output plus a registered rising-edge pulse.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  // [0],[1] synchronise, [2] holds the previous synchronised level
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], din};
      pulse  <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/tcs3200_color_detector.sv
// TCS3200 measuring front end: cycles the colour filters, counts sensor edges per
// window and emits one colour decision per measurement round.
module tcs3200_color_detector
  import tcs3200_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 1562,
  parameter int unsigned CLEAR_CYCLES  = 3,
  parameter int unsigned CNT_W         = 12,
  parameter int unsigned MIN_COUNT     = 4
) (
  input  logic       clk_3125,
  input  logic       rst_n,
  input  logic       start_sim,
  input  logic       cs_out,
  output logic [1:0] filter,
  output logic [1:0] color,
  output logic       color_valid
);

  localparam int unsigned TMR_W = $clog2(WINDOW_CYCLES + CLEAR_CYCLES);
  localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] CLR_LAST = TMR_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_COUNT);

  state_e           state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b;
  logic             edge_pulse;
  logic             win_last, clr_last;
  logic             clear_first, clear_done;
  logic [1:0]       decision_c, decision_q;

  edge_sync u_edge_sync (
    .clk   (clk_3125),
    .rst_n (rst_n),
    .din   (cs_out),
    .pulse (edge_pulse)
  );

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next-state: fixed G -> R -> B -> CLEAR rotation, start_sim low forces IDLE
  always_comb begin
    state_nxt = state;
    win_last  = (timer == WIN_LAST);
    clr_last  = (timer == CLR_LAST);
    if (!start_sim) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_GREEN;
        ST_GREEN: if (win_last) state_nxt = ST_RED;
        ST_RED:   if (win_last) state_nxt = ST_BLUE;
        ST_BLUE:  if (win_last) state_nxt = ST_CLEAR;
        ST_CLEAR: if (clr_last) state_nxt = ST_GREEN;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  assign clear_first = (state == ST_CLEAR) && (timer == '0);
  assign clear_done  = (state == ST_CLEAR) && clr_last && start_sim;

  // timer restarts on every state change and rests at zero in IDLE
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n)                                    timer <= '0;
    else if (state_nxt != state || state == ST_IDLE) timer <= '0;
    else                                           timer <= timer + 1'b1;
  end

  // saturating per-window count, cleared on window entry or abort
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input state_e          win);
    if (state_nxt == ST_IDLE || (state != win && state_nxt == win)) return '0;
    if (state == win && edge_pulse && cnt != CNT_MAX)               return cnt + 1'b1;
    return cnt;
  endfunction

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_g <= '0;
      cnt_r <= '0;
      cnt_b <= '0;
    end else begin
      cnt_g <= cnt_next(cnt_g, ST_GREEN);
      cnt_r <= cnt_next(cnt_r, ST_RED);
      cnt_b <= cnt_next(cnt_b, ST_BLUE);
    end
  end

  // a colour wins only as a strict maximum that also clears the darkness floor
  always_comb begin
    decision_c = COL_NONE;
    if (cnt_r > cnt_g && cnt_r > cnt_b && cnt_r >= MIN_CNT)      decision_c = COL_RED;
    else if (cnt_g > cnt_r && cnt_g > cnt_b && cnt_g >= MIN_CNT) decision_c = COL_GREEN;
    else if (cnt_b > cnt_r && cnt_b > cnt_g && cnt_b >= MIN_CNT) decision_c = COL_BLUE;
  end

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      filter      <= FLT_CLEAR;
      color       <= COL_NONE;
      color_valid <= 1'b0;
      decision_q  <= COL_NONE;
    end else begin
      filter      <= filter_of(state_nxt);
      color_valid <= 1'b0;
      if (clear_first) decision_q <= decision_c;
      if (clear_done) begin
        color       <= decision_q;
        color_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tcs3200_color_detector.sv
// Scoreboard bench for tcs3200_color_detector: directed colour runs, abort, reset and saturation.
`timescale 1ns/1ps
module tb_tcs3200_color_detector;

  localparam int W     = 1562;
  localparam int ROUND = 3 * 1562 + 3;

  typedef struct {
    logic [1:0] col;
    int         cyc;
  } exp_t;

  logic       clk_3125 = 1'b0;
  logic       rst_n, start_sim, start_sim_sat, cs_out;
  logic [1:0] filter, color, filter_sat, color_sat;
  logic       color_valid, color_valid_sat;

  exp_t exp_q[$];
  exp_t sat_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, c0 = 0, ph = 0, idle_per = 6;
  int   per_tab[4];
  bit   run_on = 1'b0;

  always #160 clk_3125 = ~clk_3125;

  tcs3200_color_detector dut (
    .clk_3125    (clk_3125),
    .rst_n       (rst_n),
    .start_sim   (start_sim),
    .cs_out      (cs_out),
    .filter      (filter),
    .color       (color),
    .color_valid (color_valid)
  );

  tcs3200_color_detector #(.CNT_W(6)) dut_sat (
    .clk_3125    (clk_3125),
    .rst_n       (rst_n),
    .start_sim   (start_sim_sat),
    .cs_out      (cs_out),
    .filter      (filter_sat),
    .color       (color_sat),
    .color_valid (color_valid_sat)
  );

  always @(posedge clk_3125) cyc <= cyc + 1;

  // sensor model: square wave whose period follows the bench's own window timeline
  always @(negedge clk_3125) begin
    int per;
    int p;
    p = cyc - c0;
    if (p < 0) p = 0;
    if (run_on) per = per_tab[(p % ROUND) / W];
    else        per = idle_per;
    ph = ph + 1;
    cs_out = (per > 0) && ((ph % per) < (per / 2));
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_3125) begin
    if (color_valid) begin
      if (exp_q.size() == 0) check("spurious_valid", color_valid, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("color", color, e.col);
      end
    end
  end

  always @(negedge clk_3125) begin
    if (color_valid_sat) begin
      if (sat_q.size() == 0) check("sat_spurious_valid", color_valid_sat, 0);
      else begin
        exp_t e;
        e = sat_q.pop_front();
        check("sat_valid_cycle", cyc, e.cyc);
        check("sat_color", color_sat, e.col);
      end
    end
  end

  function automatic int exp_filter(input int p);
    int q;
    q = p % ROUND;
    if (q < W)     return 3;
    if (q < 2 * W) return 0;
    if (q < 3 * W) return 1;
    return 2;
  endfunction

  task automatic start_run(input int pg, input int pr, input int pb, input int pc, input bit sat);
    @(negedge clk_3125);
    per_tab       = '{pg, pr, pb, pc};
    ph            = 0;
    c0            = cyc + 1;
    run_on        = 1'b1;
    start_sim     = 1'b1;
    start_sim_sat = sat;
  endtask

  // one full measurement round; expected result queued before the round begins
  task automatic do_run(input int pg, input int pr, input int pb, input int pc,
                        input logic [1:0] exp_col, input bit sat);
    exp_t e;
    start_run(pg, pr, pb, pc, sat);
    e.col = exp_col;
    e.cyc = c0 + ROUND;
    exp_q.push_back(e);
    if (sat) sat_q.push_back(e);
    for (int p = 0; p <= ROUND; p++) begin
      @(negedge clk_3125);
      if (p == 0 || p == W - 1 || p == W || p == 2 * W - 1 || p == 2 * W ||
          p == 3 * W - 1 || p == 3 * W || p == ROUND - 1 || p == ROUND)
        check("filter", filter, exp_filter(p));
    end
    start_sim     = 1'b0;
    start_sim_sat = 1'b0;
    run_on        = 1'b0;
    repeat (4) @(negedge clk_3125);
    check("valid_seen", exp_q.size(), 0);
    if (sat) check("sat_valid_seen", sat_q.size(), 0);
  endtask

  task automatic do_abort(input logic [1:0] held);
    start_run(16, 8, 16, 16, 1'b0);
    repeat (W + 400) @(negedge clk_3125);
    check("abort_pre_filter", filter, 0);
    start_sim = 1'b0;
    run_on    = 1'b0;
    @(negedge clk_3125);
    check("abort_filter", filter, 2);
    check("abort_color_held", color, held);
    repeat (5000) @(negedge clk_3125);
    check("abort_idle_filter", filter, 2);
    check("abort_idle_color", color, held);
  endtask

  task automatic do_reset_mid();
    start_run(10, 10, 10, 10, 1'b0);
    repeat (3000) @(negedge clk_3125);
    rst_n = 1'b0;
    #1;
    check("rstmid_filter", filter, 2);
    check("rstmid_color", color, 0);
    check("rstmid_valid", color_valid, 0);
    check("rstmid_sat_color", color_sat, 0);
    start_sim = 1'b0;
    run_on    = 1'b0;
    @(negedge clk_3125);
    rst_n = 1'b1;
    repeat (6000) @(negedge clk_3125);
    check("rstmid_idle_filter", filter, 2);
    check("rstmid_idle_color", color, 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    start_sim     = 1'b0;
    start_sim_sat = 1'b0;
    repeat (10) @(negedge clk_3125);
    check("reset_filter", filter, 2);
    check("reset_color", color, 0);
    check("reset_valid", color_valid, 0);
    check("reset_sat_filter", filter_sat, 2);
    rst_n = 1'b1;
    repeat (5000) @(negedge clk_3125);
    check("idle_filter", filter, 2);
    check("idle_color", color, 0);
    idle_per = 0;
    repeat (20) @(negedge clk_3125);

    do_run(16, 8, 16, 16, 2'd1, 1'b0);   // red dominant
    do_run(10, 16, 16, 16, 2'd2, 1'b0);  // green dominant
    do_run(18, 18, 8, 18, 2'd3, 1'b0);   // blue dominant
    do_abort(2'd3);
    do_run(16, 8, 16, 16, 2'd1, 1'b0);   // restart after abort
    // period 11 divides the window length, so all three counts are exactly equal
    do_run(11, 11, 11, 11, 2'd0, 1'b0);
    do_run(0, 0, 0, 0, 2'd0, 1'b0);      // dark
    // red saturates the 6-bit counter; wrapping would hand the win to green
    do_run(64, 4, 0, 0, 2'd1, 1'b1);
    do_reset_mid();

    check("queue_drained", exp_q.size(), 0);
    check("sat_queue_drained", sat_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
